lc3_mem_ctrl: RTL and testbench

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

---
 rtl/lc3_mem_ctrl_if.sv | 33 +++
 rtl/lc3_mem_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_ctrl_if
// Brief    : Memory request bus between the LC-3 memory controller and RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface lc3_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_ctrl
// Brief    : LC-3 MAR/MDR memory controller with keyboard, display and MCR
//            memory-mapped device registers.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_ctrl #(
    parameter logic [6:0] DEV_HI = 7'h7F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_mar,
    input  logic [15:0] addr_in,
    input  logic        ld_mdr,
    input  logic [15:0] bus_in,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    input  logic        disp_ready,
    lc3_mem_ctrl_if.master mem,
    output logic [15:0] mar,
    output logic [15:0] mdr,
    output logic        r,
    output logic        kb_ack,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    output logic        mcr_run
);

    localparam logic [8:0] C_OFF_KBSR = 9'h000;
    localparam logic [8:0] C_OFF_KBDR = 9'h002;
    localparam logic [8:0] C_OFF_DSR  = 9'h004;
    localparam logic [8:0] C_OFF_DDR  = 9'h006;
    localparam logic [8:0] C_OFF_MCR  = 9'h1FE;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic        r_mem_we;
    logic        r_kbsr_rdy;
    logic [7:0]  r_kbdr;
    logic        r_kb_ack;
    logic        r_disp_valid;
    logic [7:0]  r_disp_data;
    logic        r_mcr_run;

    logic        w_is_dev;
    logic [8:0]  w_off;
    logic        w_mem_start;
    logic        w_mem_done;
    logic        w_dev_go;
    logic        w_dev_rd;
    logic        w_dev_wr;
    logic [15:0] w_dev_rdata;
    logic        w_kbdr_rd;
    logic        w_ddr_wr;
    logic        w_mcr_wr;
    logic        w_kb_accept;
    logic        w_dsr_rdy;

    assign w_is_dev  = (r_mar[15:9] == DEV_HI);
    assign w_off     = r_mar[8:0];
    // The display is ready exactly when no character is still being offered.
    assign w_dsr_rdy = ~r_disp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_start = 1'b0;
        w_mem_done  = 1'b0;
        w_dev_go    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mio_en) begin
                    if (w_is_dev) begin
                        w_dev_go = 1'b1;
                        w_next   = S_DONE;
                    end else begin
                        w_mem_start = 1'b1;
                        w_next      = S_MEM_WAIT;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (mem.mem_ready) begin
                    w_mem_done = 1'b1;
                    w_next     = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_dev_rd  = w_dev_go & ~r_w;
    assign w_dev_wr  = w_dev_go &  r_w;
    assign w_kbdr_rd = w_dev_rd && (w_off == C_OFF_KBDR);
    assign w_ddr_wr  = w_dev_wr && (w_off == C_OFF_DDR) && w_dsr_rdy;
    assign w_mcr_wr  = w_dev_wr && (w_off == C_OFF_MCR);
    // A KBDR read in the same cycle blocks acceptance so the clear is not lost.
    assign w_kb_accept = kb_valid & ~r_kbsr_rdy & ~w_kbdr_rd;

    always_comb begin
        w_dev_rdata = 16'h0000;
        case (w_off)
            C_OFF_KBSR: w_dev_rdata = {r_kbsr_rdy, 15'b0};
            C_OFF_KBDR: w_dev_rdata = {8'b0, r_kbdr};
            C_OFF_DSR:  w_dev_rdata = {w_dsr_rdy, 15'b0};
            C_OFF_MCR:  w_dev_rdata = {r_mcr_run, 15'b0};
            default:    w_dev_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mar        <= 16'h0000;
            r_mdr        <= 16'h0000;
            r_mem_we     <= 1'b0;
            r_kbsr_rdy   <= 1'b0;
            r_kbdr       <= 8'h00;
            r_kb_ack     <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= 8'h00;
            r_mcr_run    <= 1'b1;
        end else begin
            if (ld_mar) begin
                r_mar <= addr_in;
            end

            if (w_mem_done && !r_mem_we) begin
                r_mdr <= mem.mem_rdata;
            end else if (w_dev_rd) begin
                r_mdr <= w_dev_rdata;
            end else if (ld_mdr && !mio_en) begin
                r_mdr <= bus_in;
            end

            if (w_mem_start) begin
                r_mem_we <= r_w;
            end else if (w_mem_done) begin
                r_mem_we <= 1'b0;
            end

            r_kb_ack <= w_kb_accept;
            if (w_kb_accept) begin
                r_kbdr     <= kb_data;
                r_kbsr_rdy <= 1'b1;
            end else if (w_kbdr_rd) begin
                r_kbsr_rdy <= 1'b0;
            end

            if (w_ddr_wr) begin
                r_disp_data  <= r_mdr[7:0];
                r_disp_valid <= 1'b1;
            end else if (r_disp_valid && disp_ready) begin
                r_disp_valid <= 1'b0;
            end

            if (w_mcr_wr) begin
                r_mcr_run <= r_mdr[15];
            end
        end
    end

    assign mem.mem_req   = (r_state == S_MEM_WAIT);
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mar;
    assign mem.mem_wdata = r_mdr;

    assign mar        = r_mar;
    assign mdr        = r_mdr;
    assign r          = (r_state == S_DONE);
    assign kb_ack     = r_kb_ack;
    assign disp_valid = r_disp_valid;
    assign disp_data  = r_disp_data;
    assign mcr_run    = r_mcr_run;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_ctrl
// Brief    : Self-checking bench for lc3_mem_ctrl against a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_mar = 1'b0;
    logic [15:0] addr_in = 16'h0;
    logic        ld_mdr = 1'b0;
    logic [15:0] bus_in = 16'h0;
    logic        mio_en = 1'b0;
    logic        r_w = 1'b0;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h0;
    logic        disp_ready = 1'b0;
    logic [15:0] mar, mdr;
    logic        r, kb_ack, disp_valid, mcr_run;
    logic [7:0]  disp_data;

    lc3_mem_ctrl_if mbus ();

    lc3_mem_ctrl #(.DEV_HI(7'h7F)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_mar     (ld_mar),
        .addr_in    (addr_in),
        .ld_mdr     (ld_mdr),
        .bus_in     (bus_in),
        .mio_en     (mio_en),
        .r_w        (r_w),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .disp_ready (disp_ready),
        .mem        (mbus),
        .mar        (mar),
        .mdr        (mdr),
        .r          (r),
        .kb_ack     (kb_ack),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .mcr_run    (mcr_run)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural register contents plus a sparse memory.
    logic [15:0] m_mar, m_mdr;
    logic        m_kbsr;
    logic [7:0]  m_kbdr;
    logic        m_dvalid;
    logic [7:0]  m_ddata;
    logic        m_mcr;
    logic [15:0] mem_model [int];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mar = 16'h0; m_mdr = 16'h0; m_kbsr = 1'b0; m_kbdr = 8'h0;
        m_dvalid = 1'b0; m_ddata = 8'h0; m_mcr = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] dev_read(input logic [15:0] a);
        case (a)
            16'hFE00: return m_kbsr ? 16'h8000 : 16'h0000;
            16'hFE02: return {8'h00, m_kbdr};
            16'hFE04: return m_dvalid ? 16'h0000 : 16'h8000;
            16'hFFFE: return m_mcr ? 16'h8000 : 16'h0000;
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic access(input logic [15:0] addr, input logic we,
                          input logic [15:0] wdata, input int lat);
        logic [15:0] rd;
        ld_mar = 1'b1; addr_in = addr;
        if (we) begin ld_mdr = 1'b1; bus_in = wdata; end
        tick();
        ld_mar = 1'b0; ld_mdr = 1'b0;
        m_mar = addr;
        if (we) m_mdr = wdata;
        chk16("mar_load", mar, m_mar);
        mio_en = 1'b1; r_w = we;
        tick();
        mio_en = 1'b0;
        if (addr >= 16'hFE00) begin
            if (!we) begin
                m_mdr = dev_read(addr);
                if (addr == 16'hFE02) m_kbsr = 1'b0;
            end else if (addr == 16'hFE06 && !m_dvalid) begin
                m_dvalid = 1'b1; m_ddata = m_mdr[7:0];
            end else if (addr == 16'hFFFE) begin
                m_mcr = m_mdr[15];
            end
            chk1("dev_r", r, 1'b1);
            chk1("dev_no_req", mbus.mem_req, 1'b0);
        end else begin
            for (int i = 0; i < lat; i++) begin
                chk1("mem_req_wait", mbus.mem_req, 1'b1);
                chk1("r_during_wait", r, 1'b0);
                tick();
            end
            chk1("mem_req", mbus.mem_req, 1'b1);
            chk1("mem_we", mbus.mem_we, we);
            chk16("mem_addr", mbus.mem_addr, addr);
            if (we) chk16("mem_wdata", mbus.mem_wdata, m_mdr);
            if (!mem_model.exists(int'(addr))) mem_model[int'(addr)] = 16'($urandom);
            rd = mem_model[int'(addr)];
            mbus.mem_ready = 1'b1;
            mbus.mem_rdata = rd;
            tick();
            mbus.mem_ready = 1'b0;
            mbus.mem_rdata = 16'($urandom);
            if (we) mem_model[int'(addr)] = m_mdr;
            else    m_mdr = rd;
            chk1("mem_r", r, 1'b1);
            chk1("mem_req_drop", mbus.mem_req, 1'b0);
        end
        chk16("mdr", mdr, m_mdr);
        tick();
        chk1("r_single", r, 1'b0);
        chk1("disp_valid", disp_valid, m_dvalid);
        chk16("disp_data", {8'h00, disp_data}, {8'h00, m_ddata});
        chk1("mcr_run", mcr_run, m_mcr);
    endtask

    task automatic kb_offer(input logic [7:0] ch);
        kb_valid = 1'b1; kb_data = ch;
        tick();
        chk1("kb_ack", kb_ack, 1'b1);
        kb_valid = 1'b0;
        m_kbsr = 1'b1; m_kbdr = ch;
        tick();
        chk1("kb_ack_once", kb_ack, 1'b0);
    endtask

    task automatic disp_drain();
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        m_dvalid = 1'b0;
        chk1("disp_drain", disp_valid, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd_list [6];
        logic [15:0] wr_list [4];
        mbus.mem_ready = 1'b0;
        mbus.mem_rdata = 16'h0;
        rd_list = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE08, 16'hFFFE, 16'hFFFC};
        wr_list = '{16'hFE06, 16'hFFFE, 16'hFE00, 16'hFE10};
        model_reset();
        tick();
        do_reset();
        chk16("rst_mar", mar, 16'h0000);
        chk16("rst_mdr", mdr, 16'h0000);
        chk1("rst_r", r, 1'b0);
        chk1("rst_mem_req", mbus.mem_req, 1'b0);
        chk1("rst_mem_we", mbus.mem_we, 1'b0);
        chk1("rst_kb_ack", kb_ack, 1'b0);
        chk1("rst_disp_valid", disp_valid, 1'b0);
        chk16("rst_disp_data", {8'h00, disp_data}, 16'h0000);
        chk1("rst_mcr_run", mcr_run, 1'b1);

        // Memory read, three request cycles
        mem_model[16'h3000] = 16'h1234;
        access(16'h3000, 1'b0, 16'h0, 2);
        chk16("rd3000", mdr, 16'h1234);

        // Memory write, immediate ready
        access(16'h4000, 1'b1, 16'hBEEF, 0);
        chk16("wr4000_mdr", mdr, 16'hBEEF);

        // Keyboard
        kb_offer(8'h41);
        access(16'hFE00, 1'b0, 16'h0, 0);
        chk16("kbsr_full", mdr, 16'h8000);
        access(16'hFE02, 1'b0, 16'h0, 0);
        chk16("kbdr_A", mdr, 16'h0041);
        access(16'hFE00, 1'b0, 16'h0, 0);
        chk16("kbsr_empty", mdr, 16'h0000);

        // Held offer while full, then KBDR read in the same cycle as the offer
        kb_offer(8'h41);
        kb_valid = 1'b1; kb_data = 8'h42;
        tick(); chk1("kb_full_noack0", kb_ack, 1'b0);
        tick(); chk1("kb_full_noack1", kb_ack, 1'b0);
        ld_mar = 1'b1; addr_in = 16'hFE02;
        tick(); chk1("kb_full_noack2", kb_ack, 1'b0);
        ld_mar = 1'b0; mio_en = 1'b1; r_w = 1'b0;
        tick();
        mio_en = 1'b0;
        chk1("kb_race_r", r, 1'b1);
        chk16("kb_race_old", mdr, 16'h0041);
        chk1("kb_race_noack", kb_ack, 1'b0);
        tick();
        chk1("kb_race_ack_later", kb_ack, 1'b1);
        kb_valid = 1'b0;
        m_mar = 16'hFE02; m_mdr = 16'h0041; m_kbsr = 1'b1; m_kbdr = 8'h42;
        tick();
        chk1("kb_race_ack_once", kb_ack, 1'b0);
        access(16'hFE02, 1'b0, 16'h0, 0);
        chk16("kbdr_B", mdr, 16'h0042);

        // Display
        access(16'hFE06, 1'b1, 16'h0048, 0);
        chk16("ddr_data", {8'h00, disp_data}, 16'h0048);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("disp_hold", disp_valid, 1'b1);
        end
        access(16'hFE04, 1'b0, 16'h0, 0);
        chk16("dsr_busy", mdr, 16'h0000);
        access(16'hFE06, 1'b1, 16'h0055, 0);
        chk16("ddr_drop", {8'h00, disp_data}, 16'h0048);
        disp_drain();
        access(16'hFE04, 1'b0, 16'h0, 0);
        chk16("dsr_ready", mdr, 16'h8000);

        // Machine control
        access(16'hFFFE, 1'b1, 16'h0000, 0);
        chk1("mcr_stop", mcr_run, 1'b0);
        access(16'hFFFE, 1'b0, 16'h0, 0);
        chk16("mcr_read", mdr, 16'h0000);
        do_reset();
        chk1("mcr_rst", mcr_run, 1'b1);

        // Reset during MEM_WAIT with mem_ready in the same cycle
        access(16'h0100, 1'b1, 16'h5A5A, 0);
        ld_mar = 1'b1; addr_in = 16'h3000;
        tick();
        ld_mar = 1'b0; mio_en = 1'b1; r_w = 1'b0;
        tick();
        mio_en = 1'b0;
        chk1("abort_req", mbus.mem_req, 1'b1);
        rst = 1'b1; mbus.mem_ready = 1'b1; mbus.mem_rdata = 16'hFFFF;
        tick();
        rst = 1'b0; mbus.mem_ready = 1'b0;
        model_reset();
        chk1("abort_no_r", r, 1'b0);
        chk16("abort_mdr", mdr, 16'h0000);
        chk1("abort_req_off", mbus.mem_req, 1'b0);
        tick();
        chk1("abort_no_r2", r, 1'b0);
        chk1("abort_idle", mbus.mem_req, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: access(16'($urandom_range(0, 16'hFDFF)), 1'b0, 16'h0, int'($urandom_range(0, 4)));
                1: access(16'($urandom_range(0, 16'hFDFF)), 1'b1, 16'($urandom), int'($urandom_range(0, 4)));
                2: access(rd_list[$urandom_range(0, 5)], 1'b0, 16'h0, 0);
                3: access(wr_list[$urandom_range(0, 3)], 1'b1, 16'($urandom), 0);
                4: if (!m_kbsr) kb_offer(8'($urandom));
                   else access(16'hFE02, 1'b0, 16'h0, 0);
                default: disp_drain();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
